// File: rtl/cpu19_pkg.sv
// Shared CPU19 definitions: default address width and next-PC select encodings
// used by both the decoder and the PC/return-stack unit.
package cpu19_pkg;

  localparam int unsigned CPU_AW = 19;

  localparam logic [1:0] JMP_SEQ = 2'b00;
  localparam logic [1:0] JMP_TGT = 2'b01;
  localparam logic [1:0] JMP_RSV = 2'b10;
  localparam logic [1:0] JMP_RET = 2'b11;

endpackage

// File: rtl/ras_lifo.sv
// Return-address stack: storage, depth counter, full/empty and sticky overflow.
// Define PC_STACK_RAS_WRAP_EN to make a push while full overwrite the oldest entry.
module ras_lifo
  import cpu19_pkg::*;
#(
  parameter int unsigned AW    = CPU_AW,
  parameter int unsigned DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   push,
  input  logic                   pop,
  input  logic [AW-1:0]          wdata,
  output logic [AW-1:0]          tos,
  output logic [$clog2(DEPTH):0] depth,
  output logic                   full,
  output logic                   empty,
  output logic                   ovf
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned DW = PW + 1;
`ifdef PC_STACK_RAS_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic [AW-1:0] mem [DEPTH];
  logic [PW-1:0] ptr;
  logic          do_push;
  logic          do_pop;
  logic          do_repl;

  // ptr is the next write slot; it equals depth modulo DEPTH unless wrapping occurred
  always_comb begin
    full    = (depth == DW'(DEPTH));
    empty   = (depth == '0);
    do_repl = push & pop & ~empty;
    do_push = push & ~do_repl;
    do_pop  = pop & ~push & ~empty;
    tos     = mem[ptr - PW'(1)];
  end

  always_ff @(posedge clk) begin
    if (en) begin
      if (do_repl) begin
        mem[ptr - PW'(1)] <= wdata;
      end else if (do_push && (!full || WRAP)) begin
        mem[ptr] <= wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr   <= '0;
      depth <= '0;
      ovf   <= 1'b0;
    end else if (en) begin
      if (do_push) begin
        if (!full) begin
          ptr   <= ptr + PW'(1);
          depth <= depth + DW'(1);
        end else begin
          ovf <= 1'b1;
          if (WRAP) ptr <= ptr + PW'(1);
        end
      end else if (do_pop) begin
        ptr   <= ptr - PW'(1);
        depth <= depth - DW'(1);
      end
    end
  end

endmodule

// File: rtl/pc_stack_unit.sv
// Program counter with next-PC select and a return-address stack (ras_lifo).
// Honors PC_STACK_RAS_WRAP_EN through ras_lifo (push while full overwrites oldest).
module pc_stack_unit
  import cpu19_pkg::*;
#(
  parameter int unsigned   AW       = CPU_AW,
  parameter int unsigned   DEPTH    = 8,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [1:0]             jump,
  input  logic                   push,
  input  logic                   pop,
  input  logic [AW-1:0]          target,
  output logic [AW-1:0]          pc,
  output logic [$clog2(DEPTH):0] depth,
  output logic                   full,
  output logic                   empty,
  output logic                   ovf,
  output logic                   udf
);

  logic [AW-1:0] pc_inc;
  logic [AW-1:0] pc_next;
  logic [AW-1:0] tos;
  logic          udf_set;

  ras_lifo #(
    .AW    (AW),
    .DEPTH (DEPTH)
  ) u_ras (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .push  (push),
    .pop   (pop),
    .wdata (pc_inc),
    .tos   (tos),
    .depth (depth),
    .full  (full),
    .empty (empty),
    .ovf   (ovf)
  );

  // Reserved select 10 falls through to sequential fetch
  always_comb begin
    pc_inc  = pc + AW'(1);
    pc_next = pc_inc;
    case (jump)
      JMP_TGT: pc_next = target;
      JMP_RET: pc_next = empty ? RESET_PC : tos;
      default: pc_next = pc_inc;
    endcase
    udf_set = empty & ((jump == JMP_RET) | (pop & ~push));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc  <= RESET_PC;
      udf <= 1'b0;
    end else if (en) begin
      pc <= pc_next;
      if (udf_set) udf <= 1'b1;
    end
  end

endmodule

// File: doc/pc_stack_unit.md
PC_STACK_UNIT -- requirements
Module: pc_stack_unit

Interface
REQ-001 SHALL have parameter AW, default 19, the program-counter and return-address width.
REQ-002 SHALL have parameter DEPTH, default 8, the number of return-stack entries (power of 2, at least 2).
REQ-003 SHALL have parameter RESET_PC, default 19'h00000, the PC value after reset.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port en, input, 1 bit: advance enable; 0 holds all state.
REQ-007 SHALL have port jump, input, 2 bits: next-PC select from the decoder (00 = sequential, 01 = target, 11 = return, 10 = reserved).
REQ-008 SHALL have port push, input, 1 bit: call, push return address.
REQ-009 SHALL have port pop, input, 1 bit: return, pop the stack.
REQ-010 SHALL have port target, input, AW bits: jump or branch destination.
REQ-011 SHALL have port pc, output, AW bits: the current program counter (registered).
REQ-012 SHALL have port depth, output, $clog2(DEPTH)+1 bits: the number of valid stack entries.
REQ-013 SHALL have ports full and empty, output, 1 bit each: stack status, combinational from depth.
REQ-014 SHALL have ports ovf and udf, output, 1 bit each: sticky overflow and underflow flags.

Function
REQ-015 SHALL, when en=1, compute next pc: jump=00 or 10 gives pc+1; 01 gives target; 11 gives the top-of-stack (TOS) value; arithmetic is modulo 2^AW (pc of all-ones wraps to 0).
REQ-016 SHALL make next pc visible on pc exactly one cycle after the inputs are sampled; there are no bubbles and no multi-cycle operations.
REQ-017 SHALL, on push=1, pop=0 and not full, write pc+1 (modulo 2^AW) at index depth and increment depth.
REQ-018 SHALL, on pop=1, push=0 and not empty, decrement depth; the popped value is the TOS used by jump=11 in the same cycle.
REQ-019 SHALL, on push=1 and pop=1 together, replace the TOS with pc+1 and leave depth unchanged; if empty, treat it as a push only.
REQ-020 SHALL, on jump=11 with empty=1, load pc with RESET_PC and set udf.
REQ-021 SHALL, on pop=1 with empty=1, set udf and leave depth at 0.
REQ-022 SHALL, on push=1, pop=0 and full=1, behave as defined in the Configuration section; the jump itself is still taken.
REQ-023 SHALL only update ovf and udf when en=1; once set, they are cleared only by rst.
REQ-024 SHALL ignore push, pop, jump and target entirely when en=0; pc, the stack, depth and the flags hold.
REQ-025 SHALL generate no X on any output when jump=10; it is treated as 00.

Reset
REQ-026 SHALL, when rst=1 at a clock edge, set pc=RESET_PC, depth=0, ovf=0 and udf=0, and clear any operation in progress; the stack contents are don't-care.
REQ-027 SHALL give rst priority over en and all other inputs; the first post-reset update occurs on the first edge with rst=0 and en=1.

Configuration
REQ-028 SHALL, with macro PC_STACK_RAS_WRAP_EN defined, treat a push while full as a circular overwrite: the oldest entry is discarded, the new entry becomes TOS, depth stays DEPTH, and ovf is set.
REQ-029 SHALL, without PC_STACK_RAS_WRAP_EN, treat a push while full as discarded: the stack and depth are unchanged and ovf is set.

Structure
REQ-030 SHALL obtain the AW default and the jump encodings (JMP_SEQ=2'b00, JMP_TGT=2'b01, JMP_RET=2'b11) from shared package cpu19_pkg, which the decoder also uses.
REQ-031 SHALL hold the storage, depth counter and full/empty/overflow logic in a sub-module ras_lifo; the PC register and next-PC mux stay at the top level.

Verification
REQ-032 SHALL cover reset and sequential fetch: rst for 2 cycles, then en=1 and jump=00 for 4 cycles -> pc = 0, 1, 2, 3, 4; depth=0 and empty=1.
REQ-033 SHALL cover call and return: at pc=5, jump=01, push=1, target=19'h00100 -> pc=0x100 and depth=1; later jump=11 and pop=1 -> pc=6 and depth=0.
REQ-034 SHALL cover nesting to full: 8 calls from distinct PCs -> full=1; a 9th call -> ovf=1; with WRAP_EN, 8 returns replay the newest 8 addresses; without it, 8 returns replay the first 8 addresses.
REQ-035 SHALL cover underflow: after reset, jump=11 and pop=1 -> pc=RESET_PC, udf=1 and depth=0; udf stays 1 until rst.
REQ-036 SHALL cover stall and wrap: pc=19'h7FFFF with jump=00 -> pc=0; en=0 with push=1 and jump=01 -> pc and depth unchanged.
REQ-037 SHALL cover simultaneous push and pop: depth=2 with TOS=0x20, at pc=0x40 -> next pc=0x20, TOS=0x41, depth=2.
